// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - MiniRISC fetch/decode/execute sequencer with run/step/halt debug control
module instr_sequencer #(
    parameter int ADDR_W   = 5,
    parameter int INSTR_W  = 16,
    parameter int MAX_WAIT = 15
) (
    input  logic               i_Clk,
    input  logic               i_Rst_n,
    input  logic [INSTR_W-1:0] i_Instr,
    input  logic               i_Zero,
    input  logic               i_Mem_Ready,
    input  logic               i_Run,
    input  logic               i_Step,
    output logic               o_PC_Hold,
    output logic               o_Jmp_En,
    output logic [ADDR_W-1:0]  o_Jmp_Addr,
    output logic               o_ALU_En,
    output logic               o_Reg_We,
    output logic               o_Mem_Req,
    output logic               o_Mem_We,
    output logic               o_Halted,
    output logic               o_Fault
);
    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_LOAD  = 4'h8;
    localparam logic [3:0] OP_STORE = 4'h9;
    localparam logic [3:0] OP_JMP   = 4'hA;
    localparam logic [3:0] OP_JZ    = 4'hB;
    localparam logic [3:0] OP_JNZ   = 4'hC;
    localparam logic [3:0] OP_HALT  = 4'hF;

    typedef enum logic [2:0] {
        S_HALTED,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_BRANCH,
        S_ADV,
        S_FAULT
    } state_t;

    state_t             state_q, state_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               taken_q, taken_d;
    logic               run_q, step_q;

    logic               pc_hold_q, jmp_en_q, alu_en_q, reg_we_q;
    logic               mem_req_q, mem_we_q, halted_q, fault_q;
    logic [ADDR_W-1:0]  jmp_addr_q;

    logic [3:0]         op_q, op_d;
    logic               resume;
    logic               adv_d, jump_d;

    function automatic logic is_alu(input logic [3:0] op);
        return (op >= 4'h1) && (op <= 4'h7);
    endfunction

    assign op_q   = ir_q[INSTR_W-1 -: 4];
    assign op_d   = ir_d[INSTR_W-1 -: 4];
    assign resume = (i_Run & ~run_q) | (i_Step & ~step_q);
    assign adv_d  = (state_d == S_ADV);
    assign jump_d = adv_d & taken_d;

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        cnt_d   = cnt_q;
        taken_d = taken_q;
        unique case (state_q)
            S_HALTED: begin
                if (resume) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                ir_d    = i_Instr;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                unique case (op_q)
                    OP_NOP, OP_HALT:                state_d = S_ADV;
                    4'h1, 4'h2, 4'h3, 4'h4,
                    4'h5, 4'h6, 4'h7:               state_d = S_EXEC;
                    OP_LOAD, OP_STORE: begin
                        cnt_d   = '0;
                        state_d = S_MEM;
                    end
                    OP_JMP, OP_JZ, OP_JNZ:          state_d = S_BRANCH;
                    default:                        state_d = S_FAULT;
                endcase
            end
            S_EXEC: begin
                state_d = S_ADV;
            end
            S_MEM: begin
                // Ready on the final allowed cycle still completes the access.
                if (i_Mem_Ready) begin
                    state_d = S_ADV;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(MAX_WAIT - 1)) begin
                        state_d = S_FAULT;
                    end
                end
            end
            S_BRANCH: begin
                taken_d = (op_q == OP_JMP)
                        | ((op_q == OP_JZ)  &  i_Zero)
                        | ((op_q == OP_JNZ) & ~i_Zero);
                state_d = S_ADV;
            end
            S_ADV: begin
                taken_d = 1'b0;
                if ((op_q == OP_HALT) || !i_Run) begin
                    state_d = S_HALTED;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_FAULT: begin
                state_d = S_FAULT;
            end
            default: begin
                state_d = S_FAULT;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q    <= S_HALTED;
            ir_q       <= '0;
            cnt_q      <= '0;
            taken_q    <= 1'b0;
            run_q      <= 1'b0;
            step_q     <= 1'b0;
            pc_hold_q  <= 1'b1;
            jmp_en_q   <= 1'b0;
            jmp_addr_q <= '0;
            alu_en_q   <= 1'b0;
            reg_we_q   <= 1'b0;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            halted_q   <= 1'b1;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            ir_q       <= ir_d;
            cnt_q      <= cnt_d;
            taken_q    <= taken_d;
            run_q      <= i_Run;
            step_q     <= i_Step;
            pc_hold_q  <= ~adv_d;
            jmp_en_q   <= jump_d;
            jmp_addr_q <= jump_d ? ir_d[ADDR_W-1:0] : '0;
            alu_en_q   <= (state_d == S_EXEC);
            reg_we_q   <= adv_d & (is_alu(op_d) | (op_d == OP_LOAD));
            mem_req_q  <= (state_d == S_MEM);
            mem_we_q   <= (state_d == S_MEM) & (op_d == OP_STORE);
            halted_q   <= (state_d == S_HALTED);
            fault_q    <= (state_d == S_FAULT);
        end
    end

    assign o_PC_Hold  = pc_hold_q;
    assign o_Jmp_En   = jmp_en_q;
    assign o_Jmp_Addr = jmp_addr_q;
    assign o_ALU_En   = alu_en_q;
    assign o_Reg_We   = reg_we_q;
    assign o_Mem_Req  = mem_req_q;
    assign o_Mem_We   = mem_we_q;
    assign o_Halted   = halted_q;
    assign o_Fault    = fault_q;

endmodule
